exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-low reset (RstEnable = 1'b0), sampled on the clk rising edge.
REQ-003 SHALL have port int_raw_i, input, 6 bits: asynchronous external hardware interrupt lines.
REQ-004 SHALL have port timer_int_i, input, 1 bit: timer interrupt from the CP0 register block.
REQ-005 SHALL have port mem_valid_i, input, 1 bit: MEM stage holds a real (non-bubble) instruction.
REQ-006 SHALL have port mem_stall_i, input, 1 bit: MEM stage stalled this cycle.
REQ-007 SHALL have port mem_excflags_i, input, 5 bits: {eret, overflow, trap, invalid_inst, syscall}.
REQ-008 SHALL have port mem_inst_addr_i, input, 32 bits: address of the MEM-stage instruction.
REQ-009 SHALL have port mem_in_delayslot_i, input, 1 bit: MEM-stage instruction is in a delay slot.
REQ-010 SHALL have ports cp0_status_i, cp0_cause_i and cp0_epc_i, input, 32 bits each: committed CP0 register values.
REQ-011 SHALL have ports wb_cp0_we_i (1 bit), wb_cp0_waddr_i (5 bits) and wb_cp0_wdata_i (32 bits), input: pending WB-stage CP0 write.
REQ-012 SHALL have port int_o, output, 6 bits: conditioned interrupt lines driven to the CP0 int_i input.
REQ-013 SHALL have port exception_type_o, output, 32 bits: final exception type presented to CP0.
REQ-014 SHALL have ports exc_inst_addr_o (32 bits) and exc_in_delayslot_o (1 bit), output: pass-through of the MEM instruction address and delay-slot flag.
REQ-015 SHALL have ports flush_o (1 bit) and new_pc_o (32 bits), output: pipeline flush and redirect target.
REQ-016 SHALL have port exc_count_o, output, 16 bits: number of exceptions taken.

Function
REQ-017 SHALL form effective status, cause and EPC by substituting wb_cp0_wdata_i when wb_cp0_we_i=1 and wb_cp0_waddr_i equals 12, 13 or 14 respectively; for cause, only bits 9:8, 22 and 23 SHALL be substituted.
REQ-018 SHALL drive int_o[4:0] from the conditioned int_raw_i[4:0], and int_o[5] as the conditioned int_raw_i[5] ORed with timer_int_i, where the timer path is not delayed.
REQ-019 SHALL detect an interrupt when mem_valid_i=1, status[0]=1, status[1]=0 and (cause[15:8] & status[15:8]) is nonzero, all using the effective values from REQ-017.
REQ-020 SHALL encode exception_type_o by fixed priority: interrupt 32'h1 > syscall 32'h8 > invalid_inst 32'ha > trap 32'hd > overflow 32'hc > eret 32'he; the value SHALL be 0 if no source is present.
REQ-021 SHALL drive exception_type_o to 0 when mem_valid_i=0, when mem_stall_i=1, or when the FSM is in HOLD.
REQ-022 SHALL derive exception_type_o, flush_o and new_pc_o combinationally in the same cycle as the MEM inputs (zero-cycle latency).
REQ-023 SHALL assert flush_o=1 exactly when exception_type_o is nonzero.
REQ-024 SHALL set new_pc_o to the effective EPC for eret, to 32'h0000_0020 for all other exception types, and to 0 otherwise.
REQ-025 SHALL implement an FSM with states IDLE and HOLD: IDLE transitions to HOLD on a cycle with flush_o=1; HOLD transitions to IDLE unconditionally after one cycle.
REQ-026 SHALL keep flush_o=0 in HOLD, so that back-to-back flushes are impossible.
REQ-027 SHALL increment exc_count_o on each flush with eret excluded, saturating at 16'hFFFF.

Reset
REQ-028 SHALL, while rst=0 at a clock edge, set the FSM to IDLE, exc_count_o to 0 and all synchronizer flops to 0.
REQ-029 SHALL hold exception_type_o, flush_o and new_pc_o at 0 during reset.
REQ-030 SHALL allow reset asserted while in HOLD to return the FSM to IDLE at that same edge.

Configuration
REQ-031 SHALL, with the macro EXC_INT_SYNC_EN defined, pass int_raw_i through a 2-flop synchronizer, giving 2 cycles of latency to int_o.
REQ-032 SHALL, without EXC_INT_SYNC_EN, pass int_raw_i through a single register, giving 1 cycle of latency.

Verification
REQ-033 SHALL cover: status=32'h0000_0401 and int_raw_i[0] raised at cycle 0, with EXC_INT_SYNC_EN -> int_o[0]=1 at cycle 2; once cause[10] reflects it and a valid MEM instruction is present, exception_type_o=32'h1, flush_o=1 and new_pc_o=32'h20.
REQ-034 SHALL cover: syscall and overflow flags together at mem_inst_addr_i=32'h100 -> exception_type_o=32'h8, new_pc_o=32'h20, exc_inst_addr_o=32'h100.
REQ-035 SHALL cover: eret with cp0_epc_i=32'h40 and a WB write of 32'h80 to register 14 in the same cycle -> new_pc_o=32'h80 and exc_count_o unchanged.
REQ-036 SHALL cover: two consecutive cycles with invalid_inst -> flush_o=1 then 0 (HOLD), returning to IDLE on the third cycle.
REQ-037 SHALL cover: overflow with mem_stall_i=1 -> flush_o=0; after the stall is released -> exception_type_o=32'hc.
REQ-038 SHALL cover: exc_count_o preloaded to 16'hFFFF by 65535 flushes, then one more trap -> exc_count_o stays 16'hFFFF.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception controller for the MEM stage: interrupt conditioning, prioritised exception
// encoding, flush/redirect generation, one-cycle flush lockout and a saturating count.
// Optional macro EXC_INT_SYNC_EN selects a 2-flop interrupt synchronizer (else 1 register).
module exc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_raw_i,
    input  logic        timer_int_i,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic [4:0]  mem_excflags_i,
    input  logic [31:0] mem_inst_addr_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [5:0]  int_o,
    output logic [31:0] exception_type_o,
    output logic [31:0] exc_inst_addr_o,
    output logic        exc_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [15:0] exc_count_o
);

    localparam logic [4:0]  CP0_STATUS = 5'd12;
    localparam logic [4:0]  CP0_CAUSE  = 5'd13;
    localparam logic [4:0]  CP0_EPC    = 5'd14;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
    localparam logic [31:0] EXC_VECTOR  = 32'h0000_0020;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] exc_count_q, exc_count_d;
    logic [5:0]  int_sync_q;
    logic [31:0] status_eff, cause_eff, epc_eff;
    logic        int_pending;
    logic [31:0] exc_raw;

    // ---------------- interrupt line conditioning ----------------
`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_meta_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            int_meta_q <= 6'd0;
            int_sync_q <= 6'd0;
        end else begin
            int_meta_q <= int_raw_i;
            int_sync_q <= int_meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_sync_q <= 6'd0;
        end else begin
            int_sync_q <= int_raw_i;
        end
    end
`endif

    // Timer interrupt is already synchronous to clk, so it bypasses the register stage.
    assign int_o = {int_sync_q[5] | timer_int_i, int_sync_q[4:0]};

    // ---------------- CP0 forwarding from WB ----------------
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                CP0_STATUS: status_eff = wb_cp0_wdata_i;
                CP0_CAUSE: begin
                    // Only the software-writable cause fields are forwarded.
                    cause_eff[9:8]   = wb_cp0_wdata_i[9:8];
                    cause_eff[23:22] = wb_cp0_wdata_i[23:22];
                end
                CP0_EPC:    epc_eff = wb_cp0_wdata_i;
                default: ;
            endcase
        end
    end

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2],
                               cause_eff[31:16], cause_eff[7:0]};

    assign int_pending = status_eff[0] & ~status_eff[1] &
                         (|(cause_eff[15:8] & status_eff[15:8]));

    // Flag order: {eret, overflow, trap, invalid_inst, syscall}
    always_comb begin
        exc_raw = EXC_NONE;
        if (int_pending)            exc_raw = EXC_INT;
        else if (mem_excflags_i[0]) exc_raw = EXC_SYSCALL;
        else if (mem_excflags_i[1]) exc_raw = EXC_INVALID;
        else if (mem_excflags_i[2]) exc_raw = EXC_TRAP;
        else if (mem_excflags_i[3]) exc_raw = EXC_OVF;
        else if (mem_excflags_i[4]) exc_raw = EXC_ERET;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_o) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        exception_type_o = EXC_NONE;
        flush_o          = 1'b0;
        new_pc_o         = 32'd0;
        if (rst && mem_valid_i && !mem_stall_i && (state_q == IDLE)) begin
            exception_type_o = exc_raw;
        end
        if (exception_type_o != EXC_NONE) begin
            flush_o  = 1'b1;
            new_pc_o = (exception_type_o == EXC_ERET) ? epc_eff : EXC_VECTOR;
        end
    end

    assign exc_inst_addr_o    = mem_inst_addr_i;
    assign exc_in_delayslot_o = mem_in_delayslot_i;

    // ---------------- saturating exception counter ----------------
    always_comb begin
        exc_count_d = exc_count_q;
        if (flush_o && (exception_type_o != EXC_ERET) && (exc_count_q != 16'hFFFF)) begin
            exc_count_d = exc_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exc_count_q <= 16'd0;
        end else begin
            exc_count_q <= exc_count_d;
        end
    end

    assign exc_count_o = exc_count_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: per-cycle expected outputs from a small reference
// model go through a scoreboard queue; directed cases plus a short random phase.
module tb_exc_ctrl;

    localparam logic [31:0] E_ERET = 32'h0000_000e;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_raw;
    logic        timer_int;
    logic        mem_valid;
    logic        mem_stall;
    logic [4:0]  mem_excflags;
    logic [31:0] mem_inst_addr;
    logic        mem_in_delayslot;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        wb_cp0_we;
    logic [4:0]  wb_cp0_waddr;
    logic [31:0] wb_cp0_wdata;
    logic [5:0]  int_out;
    logic [31:0] exception_type;
    logic [31:0] exc_inst_addr;
    logic        exc_in_delayslot;
    logic        flush;
    logic [31:0] new_pc;
    logic [15:0] exc_count;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .int_raw_i          (int_raw),
        .timer_int_i        (timer_int),
        .mem_valid_i        (mem_valid),
        .mem_stall_i        (mem_stall),
        .mem_excflags_i     (mem_excflags),
        .mem_inst_addr_i    (mem_inst_addr),
        .mem_in_delayslot_i (mem_in_delayslot),
        .cp0_status_i       (cp0_status),
        .cp0_cause_i        (cp0_cause),
        .cp0_epc_i          (cp0_epc),
        .wb_cp0_we_i        (wb_cp0_we),
        .wb_cp0_waddr_i     (wb_cp0_waddr),
        .wb_cp0_wdata_i     (wb_cp0_wdata),
        .int_o              (int_out),
        .exception_type_o   (exception_type),
        .exc_inst_addr_o    (exc_inst_addr),
        .exc_in_delayslot_o (exc_in_delayslot),
        .flush_o            (flush),
        .new_pc_o           (new_pc),
        .exc_count_o        (exc_count)
    );

    typedef struct {
        logic [31:0] etype;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        ds;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          txn      = 0;
    logic        hold_m   = 1'b0;
    logic [15:0] cnt_m    = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One MEM-stage cycle: drive, predict, compare combinational outputs, then the count.
    task automatic step(input logic valid, input logic stall, input logic [4:0] flags,
                        input logic [31:0] addr);
        exp_t        e;
        logic [31:0] st, ca, ep, t;
        @(negedge clk);
        mem_valid        = valid;
        mem_stall        = stall;
        mem_excflags     = flags;
        mem_inst_addr    = addr;
        mem_in_delayslot = addr[2];

        st = cp0_status;
        ca = cp0_cause;
        ep = cp0_epc;
        if (wb_cp0_we && wb_cp0_waddr == 5'd12) st = wb_cp0_wdata;
        if (wb_cp0_we && wb_cp0_waddr == 5'd13) begin
            ca[9:8]   = wb_cp0_wdata[9:8];
            ca[23:22] = wb_cp0_wdata[23:22];
        end
        if (wb_cp0_we && wb_cp0_waddr == 5'd14) ep = wb_cp0_wdata;

        t = 32'd0;
        if (rst && valid && !stall && !hold_m) begin
            if (st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0)) t = 32'h1;
            else if (flags[0]) t = 32'h8;
            else if (flags[1]) t = 32'ha;
            else if (flags[2]) t = 32'hd;
            else if (flags[3]) t = 32'hc;
            else if (flags[4]) t = 32'he;
        end
        e.etype = t;
        e.flush = (t != 32'd0);
        e.pc    = (t == E_ERET) ? ep : ((t != 32'd0) ? 32'h20 : 32'd0);
        e.addr  = addr;
        e.ds    = addr[2];
        sb_q.push_back(e);

        #2;
        e = sb_q.pop_front();
        check_val($sformatf("t%0d.type", txn), exception_type, e.etype);
        check_val($sformatf("t%0d.flush", txn), {31'd0, flush}, {31'd0, e.flush});
        check_val($sformatf("t%0d.new_pc", txn), new_pc, e.pc);
        check_val($sformatf("t%0d.addr", txn), exc_inst_addr, e.addr);
        check_val($sformatf("t%0d.ds", txn), {31'd0, exc_in_delayslot}, {31'd0, e.ds});

        if (!rst) begin
            hold_m = 1'b0;
            cnt_m  = 16'd0;
        end else begin
            if (e.flush && e.etype != E_ERET && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            hold_m = e.flush;
        end
        @(posedge clk);
        #1;
        check_val($sformatf("t%0d.count", txn), {16'd0, exc_count}, {16'd0, cnt_m});
        $display("txn %0d: valid=%b stall=%b flags=%b type=%h flush=%b pc=%h count=%h",
                 txn, valid, stall, flags, e.etype, e.flush, e.pc, cnt_m);
        txn++;
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; int_raw = 6'h3f; timer_int = 1'b0;
        mem_valid = 1'b0; mem_stall = 1'b0; mem_excflags = 5'd0;
        mem_inst_addr = 32'd0; mem_in_delayslot = 1'b0;
        cp0_status = 32'd0; cp0_cause = 32'd0; cp0_epc = 32'd0;
        wb_cp0_we = 1'b0; wb_cp0_waddr = 5'd0; wb_cp0_wdata = 32'd0;

        // Reset: outputs held low even with a syscall present, flops cleared.
        step(1'b1, 1'b0, 5'b00001, 32'h10);
        step(1'b1, 1'b0, 5'b00001, 32'h14);
        check_val("reset.int_o", {26'd0, int_out}, 32'd0);
        rst = 1'b1;
        int_raw = 6'd0;
        bubble();
        bubble();
        check_val("idle.int_o", {26'd0, int_out}, 32'd0);

        // Interrupt line latency through the conditioning stage.
        int_raw = 6'h01;
        bubble();
`ifdef EXC_INT_SYNC_EN
        check_val("int_lat.c1", {26'd0, int_out}, 32'h00);
`else
        check_val("int_lat.c1", {26'd0, int_out}, 32'h01);
`endif
        bubble();
        check_val("int_lat.c2", {26'd0, int_out}, 32'h01);
        timer_int = 1'b1;
        #1;
        check_val("timer.int_o", {26'd0, int_out}, 32'h21);
        timer_int = 1'b0;

        // Hardware interrupt taken once cause[10] reflects it.
        cp0_status = 32'h0000_0401;
        cp0_cause  = 32'h0000_0400;
        step(1'b1, 1'b0, 5'd0, 32'h200);
        step(1'b1, 1'b0, 5'd0, 32'h204);
        cp0_status = 32'h0000_0403;
        step(1'b1, 1'b0, 5'd0, 32'h208);
        wb_cp0_we = 1'b1; wb_cp0_waddr = 5'd12; wb_cp0_wdata = 32'h0000_0401;
        step(1'b1, 1'b0, 5'd0, 32'h20c);
        bubble();

        // Cause forwarding: bits 9:8 forwarded, bit 10 is not.
        cp0_status = 32'h0000_0301; cp0_cause = 32'd0;
        wb_cp0_waddr = 5'd13; wb_cp0_wdata = 32'h0000_0100;
        step(1'b1, 1'b0, 5'd0, 32'h300);
        bubble();
        cp0_status = 32'h0000_0401; wb_cp0_wdata = 32'h0000_0400;
        step(1'b1, 1'b0, 5'd0, 32'h304);
        wb_cp0_we = 1'b0;
        cp0_status = 32'd0;
        int_raw = 6'd0;

        // Priority and eret redirect.
        step(1'b1, 1'b0, 5'b01001, 32'h100);
        bubble();
        step(1'b1, 1'b0, 5'b11110, 32'h104);
        bubble();
        step(1'b1, 1'b0, 5'b11100, 32'h108);
        bubble();
        step(1'b1, 1'b0, 5'b11000, 32'h10c);
        bubble();
        cp0_epc = 32'h40;
        wb_cp0_we = 1'b1; wb_cp0_waddr = 5'd14; wb_cp0_wdata = 32'h80;
        step(1'b1, 1'b0, 5'b10000, 32'h110);
        bubble();
        wb_cp0_waddr = 5'd15;
        step(1'b1, 1'b0, 5'b10000, 32'h114);
        bubble();
        wb_cp0_we = 1'b0;

        // Back-to-back invalid_inst: flush, HOLD, then IDLE again.
        step(1'b1, 1'b0, 5'b00010, 32'h400);
        step(1'b1, 1'b0, 5'b00010, 32'h404);
        step(1'b1, 1'b0, 5'b00010, 32'h408);
        bubble();

        // Stalled overflow is suppressed until the stall releases.
        step(1'b1, 1'b1, 5'b01000, 32'h500);
        step(1'b1, 1'b0, 5'b01000, 32'h500);
        bubble();

        // Reset while in HOLD.
        step(1'b1, 1'b0, 5'b00100, 32'h600);
        rst = 1'b0;
        step(1'b1, 1'b0, 5'b00100, 32'h604);
        rst = 1'b1;
        step(1'b1, 1'b0, 5'b00100, 32'h608);
        bubble();

        // Counter saturation: preload one below full scale, then two traps.
        @(negedge clk);
        force dut.exc_count_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.exc_count_q;
        cnt_m = 16'hFFFE;
        step(1'b1, 1'b0, 5'b00100, 32'h700);
        bubble();
        step(1'b1, 1'b0, 5'b00100, 32'h704);
        bubble();

        // Random mix.
        for (int i = 0; i < 40; i++) begin
            cp0_status = {16'd0, 6'($urandom), 6'd0, 2'($urandom_range(0, 3) == 0 ? 2'b10 : 2'b01)};
            cp0_cause  = {16'd0, 6'($urandom), 2'($urandom), 8'd0};
            wb_cp0_we    = 1'($urandom);
            wb_cp0_waddr = 5'($urandom_range(11, 15));
            wb_cp0_wdata = $urandom;
            cp0_epc      = $urandom;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 5'($urandom), {$urandom} & 32'hffff_fffc | {29'd0, 1'($urandom), 2'b00});
        end

        if (sb_q.size() != 0) check_val("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
